// File: rtl/des_result_fifo.sv
// -----------------------------------------------------------------------------
// des_result_fifo
// Result buffer between the triple-DES core and the AHB-Lite slave controller.
// Every block flagged by the core's `done` pulse is pushed into a small
// circular FIFO. The slave controller drains it with single-cycle read
// requests, so back-to-back encryptions survive a slow bus master.
//
// Ports
//   HCLK      clock, all state changes on the rising edge
//   HRESET    asynchronous active-low reset
//   clear     synchronous flush of contents and overflow (dominates)
//   done      one-cycle pulse, in_data valid
//   in_data   completed output block from the DES core
//   in_ready  combinational ~full, used to gate the core's enable
//   rd_req    pop request from the slave controller
//   rd_data   registered head entry of the last accepted pop
//   rd_valid  one-cycle pulse, rd_data updated this cycle
//   count     number of stored entries
//   full      count == DEPTH
//   empty     count == 0
//   overflow  sticky, a done pulse was dropped because the FIFO was full
// -----------------------------------------------------------------------------
module des_result_fifo #(
  parameter int DEPTH      = 4,
  parameter int DATA_WIDTH = 64
) (
  input  logic                         HCLK,
  input  logic                         HRESET,
  input  logic                         clear,
  input  logic                         done,
  input  logic [DATA_WIDTH-1:0]        in_data,
  output logic                         in_ready,
  input  logic                         rd_req,
  output logic [DATA_WIDTH-1:0]        rd_data,
  output logic                         rd_valid,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full,
  output logic                         empty,
  output logic                         overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = $clog2(DEPTH+1);

  logic [DATA_WIDTH-1:0] mem [DEPTH];
  logic [PW-1:0]         wp;
  logic [PW-1:0]         rp;
  logic                  rd_acc;
  logic                  wr_acc;

  // Flags decode straight from the registered counter.
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign in_ready = ~full;

  // NOTE: every signal driven here gets a value on every path, so no latch
  // can be inferred.
  always_comb begin
    // A read never falls through an empty FIFO, even with a same-cycle write.
    rd_acc = rd_req & ~empty & ~clear;
    // When full, a same-cycle pop frees the slot the write needs.
    wr_acc = done & (~full | rd_acc) & ~clear;
  end

  // NOTE: the storage array has no reset; stale contents are unreachable once
  // the pointers and count are cleared, and leaving it out keeps it plain
  // flops/RAM without a reset tree.
  always_ff @(posedge HCLK) begin
    if (wr_acc) begin
      mem[wp] <= in_data;
    end
  end

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values; when full, mem[rp] below still reads the old
  // head even though the write targets the same slot.
  always_ff @(posedge HCLK or negedge HRESET) begin
    if (!HRESET) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
      rd_data  <= '0;
    end else if (clear) begin
      wp       <= '0;
      rp       <= '0;
      count    <= '0;
      overflow <= 1'b0;
      rd_valid <= 1'b0;
    end else begin
      rd_valid <= rd_acc;
      if (rd_acc) begin
        rd_data <= mem[rp];
        rp      <= rp + PW'(1);
      end
      if (wr_acc) begin
        wp <= wp + PW'(1);
      end
      if (done && !wr_acc) begin
        overflow <= 1'b1;
      end
      case ({wr_acc, rd_acc})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule
